hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It replaces the fixed two-operand bypass selector with NREAD EX read ports. It adds load-use stall generation and a sequential scoreboard for one multi-cycle MDU (mul/div) instruction in flight. It sits beside the ID/EX pipeline registers and drives the EX operand muxes, the IF/ID hold enables, the ID/EX bubble insert and the MDU writeback request.

## Interface
- NREAD, 2: number of source-register read ports per instruction (1..4)
- MDU_LAT, 4: cycles from MDU launch to result ready (2..31)
- clk  in  1  pipeline clock
- rstn  in  1  asynchronous, active-low reset
- rs_ID  in  5*NREAD  source register numbers in ID, port i at [5i+4:5i]
- rs_used_ID  in  NREAD  port i of the ID instruction actually reads its register
- is_mdu_ID  in  1  ID instruction is an MDU op
- rs_EX  in  5*NREAD  source register numbers in EX
- rd_EX, rd_MEM, rd_WB  in  5 each  destination registers
- reg_write_EX, reg_write_MEM, reg_write_WB  in  1 each  stage writes rd
- mem_read_EX  in  1  EX instruction is a load
- is_mdu_EX  in  1  EX instruction is an MDU op; its reg_write_EX is ignored
- kill_EX  in  1  EX instruction is squashed this cycle (branch flush); no MDU launch
- forward_sel  out  2*NREAD  per port: 00 regfile/EX, 01 MEM, 10 WB, 11 MDU result
- stall_IF, stall_ID  out  1 each  hold PC and IF/ID
- bubble_EX  out  1  load zeros (NOP) into ID/EX
- mdu_busy  out  1  MDU op in flight
- mdu_wb_valid  out  1  MDU result writes back this cycle
- mdu_wb_rd  out  5  destination of the MDU result

## Operation
- Forwarding per port i is combinational, with priority MEM > WB > MDU > none.
- MEM hit: reg_write_MEM && rd_MEM!=0 && rd_MEM==rs_EX[i]. WB hit uses the same form.
- MDU hit: mdu_wb_valid && mdu_wb_rd!=0 && mdu_wb_rd==rs_EX[i].
- Load-use stall: mem_read_EX && reg_write_EX && rd_EX!=0 && any port i with rs_used_ID[i] && rs_ID[i]==rd_EX.
- Scoreboard FSM states:
  - IDLE: if is_mdu_EX && !kill_EX && !bubble_EX, latch pend_rd=rd_EX, cnt=MDU_LAT-1, go BUSY.
  - BUSY: cnt decrements each cycle. At cnt==1, go DONE.
  - DONE, one cycle: mdu_wb_valid=1, mdu_wb_rd=pend_rd. Next state is IDLE. If a new launch occurs in the same cycle, next state is BUSY with the new rd.
- MDU stall: state!=IDLE and any used rs_ID[i]==pend_rd with pend_rd!=0. Also stall when is_mdu_ID && state==BUSY (one MDU in flight).
- In DONE the MDU operand is forwarded, so there is no stall on pend_rd.
- Any stall asserts stall_IF, stall_ID and bubble_EX together.
- rd==0 never causes a stall or a forward.

## Timing
- Reset (rstn low, asynchronous): state IDLE, cnt 0, pend_rd 0.
  - mdu_busy=0, mdu_wb_valid=0, mdu_wb_rd=0.
  - stall/bubble outputs are 0 unless the combinational load-use condition holds.
  - forward_sel follows its inputs.
- Launch at edge t gives mdu_wb_valid high during cycle t+MDU_LAT-1 relative to the launch cycle. The result is visible exactly MDU_LAT cycles after launch.
- mdu_busy = (state!=IDLE).
- Load-use stall lasts exactly one cycle: the bubble clears mem_read_EX.
- A load-use stall and an MDU stall in the same cycle are ORed into a single stall.
- An MDU launch is blocked while bubble_EX is set.
- kill_EX in the launch cycle: no launch, and the FSM stays IDLE.
- Reset deasserted mid-BUSY: the pending op is dropped and no writeback is issued.
- cnt width is $clog2(MDU_LAT)+1.

## Structure
- Shared package (pipeline_pkg):
  - forward-select localparams FWD_NONE/FWD_MEM/FWD_WB/FWD_MDU
  - MDU FSM state enum
  - register-index width constant REG_AW=5
- One sub-module, fwd_port_sel: the combinational per-port priority selector, instantiated NREAD times with generate.
- The FSM, counter and stall logic live in the top module.

## Test plan
- rs_EX[0]=5, rd_MEM=5 reg_write_MEM=1, rd_WB=5 reg_write_WB=1 -> forward_sel[1:0]=01. Drop MEM write -> 10.
- rd_MEM=0 reg_write_MEM=1, rs_EX[1]=0 -> forward_sel[3:2]=00.
- Load x7 in EX, ID rs_ID[1]=7 used -> stall_IF=stall_ID=bubble_EX=1 for one cycle. Same case with rs_used_ID[1]=0 -> no stall.
- MDU launch rd=9, MDU_LAT=4:
  - mdu_busy high from the next cycle
  - ID reading x9 stalls until DONE
  - mdu_wb_valid=1 with mdu_wb_rd=9 exactly 4 cycles after launch
  - rs_EX=9 in that cycle -> forward_sel=11
- Second MDU op in ID while BUSY -> stall until DONE. A back-to-back launch in DONE -> BUSY with the new rd and no gap.
- kill_EX=1 with is_mdu_EX=1 -> no launch. rstn low mid-BUSY -> all outputs reset and no mdu_wb_valid afterwards.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: forward-select codes, MDU scoreboard states, register index width.
// Pure declarations; no logic, no latency, no flow control.
package pipeline_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;
   localparam logic [1:0] FWD_MDU  = 2'b11;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-port EX operand bypass select, priority MEM > WB > MDU > regfile.
// Purely combinational, zero latency; never stalls.
module fwd_port_sel
   import pipeline_pkg::*;
(
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rd_mem,
   input  logic              reg_write_mem,
   input  logic [REG_AW-1:0] rd_wb,
   input  logic              reg_write_wb,
   input  logic              mdu_wb_valid,
   input  logic [REG_AW-1:0] mdu_wb_rd,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_NONE;
      if (reg_write_mem && rd_mem != '0 && rd_mem == rs)
         sel = FWD_MEM;
      else if (reg_write_wb && rd_wb != '0 && rd_wb == rs)
         sel = FWD_WB;
      else if (mdu_wb_valid && mdu_wb_rd != '0 && mdu_wb_rd == rs)
         sel = FWD_MDU;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding control: combinational bypass selects and stalls, plus a scoreboard for one MDU op.
// MDU result written back MDU_LAT cycles after launch; stall holds IF/ID and bubbles ID/EX.
module hazard_forward_unit
   import pipeline_pkg::*;
#(
   parameter int NREAD   = 2,
   parameter int MDU_LAT = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [REG_AW*NREAD-1:0] rs_ID,
   input  logic [NREAD-1:0]        rs_used_ID,
   input  logic                    is_mdu_ID,
   input  logic [REG_AW*NREAD-1:0] rs_EX,
   input  logic [REG_AW-1:0]       rd_EX,
   input  logic [REG_AW-1:0]       rd_MEM,
   input  logic [REG_AW-1:0]       rd_WB,
   input  logic                    reg_write_EX,
   input  logic                    reg_write_MEM,
   input  logic                    reg_write_WB,
   input  logic                    mem_read_EX,
   input  logic                    is_mdu_EX,
   input  logic                    kill_EX,
   output logic [2*NREAD-1:0]      forward_sel,
   output logic                    stall_IF,
   output logic                    stall_ID,
   output logic                    bubble_EX,
   output logic                    mdu_busy,
   output logic                    mdu_wb_valid,
   output logic [REG_AW-1:0]       mdu_wb_rd
);

   localparam int              CW       = $clog2(MDU_LAT) + 1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(MDU_LAT - 1);

   mdu_state_t        state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [REG_AW-1:0] pend_rd, pend_rd_nxt;
   logic              load_cand, load_use, mdu_dep, stall, launch;

   for (genvar i = 0; i < NREAD; i++) begin : g_port
      fwd_port_sel u_sel (
         .rs            (rs_EX[REG_AW*i +: REG_AW]),
         .rd_mem        (rd_MEM),
         .reg_write_mem (reg_write_MEM),
         .rd_wb         (rd_WB),
         .reg_write_wb  (reg_write_WB),
         .mdu_wb_valid  (mdu_wb_valid),
         .mdu_wb_rd     (mdu_wb_rd),
         .sel           (forward_sel[2*i +: 2])
      );
   end

   assign load_cand = mem_read_EX && reg_write_EX && rd_EX != '0;

   // In DONE the result is bypassed, so only BUSY blocks readers of pend_rd.
   always_comb begin
      load_use = 1'b0;
      mdu_dep  = 1'b0;
      for (int i = 0; i < NREAD; i++) begin
         if (load_cand && rs_used_ID[i] && rs_ID[REG_AW*i +: REG_AW] == rd_EX)
            load_use = 1'b1;
         if (state == MDU_BUSY && pend_rd != '0 && rs_used_ID[i] &&
             rs_ID[REG_AW*i +: REG_AW] == pend_rd)
            mdu_dep = 1'b1;
      end
   end

   assign stall     = load_use || mdu_dep || (is_mdu_ID && state == MDU_BUSY);
   assign stall_IF  = stall;
   assign stall_ID  = stall;
   assign bubble_EX = stall;
   assign launch    = is_mdu_EX && !kill_EX && !bubble_EX;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pend_rd_nxt = pend_rd;
      case (state)
         MDU_IDLE, MDU_DONE: begin
            state_nxt = MDU_IDLE;
            if (launch) begin
               state_nxt   = MDU_BUSY;
               cnt_nxt     = CNT_LOAD;
               pend_rd_nxt = rd_EX;
            end
         end
         MDU_BUSY: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1))
               state_nxt = MDU_DONE;
         end
         default: state_nxt = MDU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= MDU_IDLE;
         cnt     <= '0;
         pend_rd <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pend_rd <= pend_rd_nxt;
      end
   end

   assign mdu_busy     = (state != MDU_IDLE);
   assign mdu_wb_valid = (state == MDU_DONE);
   assign mdu_wb_rd    = mdu_wb_valid ? pend_rd : '0;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed test-plan cases plus a random phase against a timestamp model.
// Expected outputs are queued when inputs are driven and compared when the DUT outputs are sampled.
module tb_hazard_forward_unit;

   localparam int NREAD = 2;
   localparam int LAT   = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic [9:0]      rs_ID, rs_EX;
   logic [1:0]      rs_used_ID;
   logic            is_mdu_ID;
   logic [4:0]      rd_EX, rd_MEM, rd_WB;
   logic            reg_write_EX, reg_write_MEM, reg_write_WB;
   logic            mem_read_EX, is_mdu_EX, kill_EX;
   logic [3:0]      forward_sel;
   logic            stall_IF, stall_ID, bubble_EX, mdu_busy, mdu_wb_valid;
   logic [4:0]      mdu_wb_rd;

   typedef struct {
      logic [3:0] fwd;
      logic       stall;
      logic       busy;
      logic       wbv;
      logic [4:0] wbrd;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         launch_at = -1;
   logic [4:0] m_rd = '0;
   bit         pend_launch = 1'b0;
   logic [4:0] pend_rd = '0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.NREAD(NREAD), .MDU_LAT(LAT)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .rs_ID         (rs_ID),
      .rs_used_ID    (rs_used_ID),
      .is_mdu_ID     (is_mdu_ID),
      .rs_EX         (rs_EX),
      .rd_EX         (rd_EX),
      .rd_MEM        (rd_MEM),
      .rd_WB         (rd_WB),
      .reg_write_EX  (reg_write_EX),
      .reg_write_MEM (reg_write_MEM),
      .reg_write_WB  (reg_write_WB),
      .mem_read_EX   (mem_read_EX),
      .is_mdu_EX     (is_mdu_EX),
      .kill_EX       (kill_EX),
      .forward_sel   (forward_sel),
      .stall_IF      (stall_IF),
      .stall_ID      (stall_ID),
      .bubble_EX     (bubble_EX),
      .mdu_busy      (mdu_busy),
      .mdu_wb_valid  (mdu_wb_valid),
      .mdu_wb_rd     (mdu_wb_rd)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   task automatic clear_inputs();
      rs_ID = '0; rs_EX = '0; rs_used_ID = '0; is_mdu_ID = 1'b0;
      rd_EX = '0; rd_MEM = '0; rd_WB = '0;
      reg_write_EX = 1'b0; reg_write_MEM = 1'b0; reg_write_WB = 1'b0;
      mem_read_EX = 1'b0; is_mdu_EX = 1'b0; kill_EX = 1'b0;
   endtask

   // Model: the op launched in cycle launch_at writes back in cycle launch_at+LAT.
   task automatic eval();
      exp_t       e, g;
      logic [4:0] r;
      bit         busy_any, done, bsy, lu, ms;
      busy_any = rstn && launch_at >= 0 && cyc > launch_at && cyc <= launch_at + LAT;
      done     = busy_any && cyc == launch_at + LAT;
      bsy      = busy_any && !done;
      for (int i = 0; i < NREAD; i++) begin
         r = rs_EX[5*i +: 5];
         if (reg_write_MEM && rd_MEM != 0 && rd_MEM == r)   e.fwd[2*i +: 2] = 2'b01;
         else if (reg_write_WB && rd_WB != 0 && rd_WB == r) e.fwd[2*i +: 2] = 2'b10;
         else if (done && m_rd != 0 && m_rd == r)           e.fwd[2*i +: 2] = 2'b11;
         else                                               e.fwd[2*i +: 2] = 2'b00;
      end
      lu = 1'b0;
      ms = bsy && is_mdu_ID;
      for (int i = 0; i < NREAD; i++) begin
         if (rs_used_ID[i] && mem_read_EX && reg_write_EX && rd_EX != 0 && rs_ID[5*i +: 5] == rd_EX)
            lu = 1'b1;
         if (rs_used_ID[i] && bsy && m_rd != 0 && rs_ID[5*i +: 5] == m_rd)
            ms = 1'b1;
      end
      e.stall = lu || ms;
      e.busy  = busy_any;
      e.wbv   = done;
      e.wbrd  = m_rd;
      sb.push_back(e);
      pend_launch = rstn && !bsy && is_mdu_EX && !kill_EX && !e.stall;
      pend_rd     = rd_EX;
      #2;
      chk("sb_level", sb.size(), 1);
      if (sb.size() > 0) begin
         g = sb.pop_front();
         chk("fwd", {28'd0, forward_sel}, {28'd0, g.fwd});
         chk("stall_IF", {31'd0, stall_IF}, {31'd0, g.stall});
         chk("stall_ID", {31'd0, stall_ID}, {31'd0, g.stall});
         chk("bubble_EX", {31'd0, bubble_EX}, {31'd0, g.stall});
         chk("mdu_busy", {31'd0, mdu_busy}, {31'd0, g.busy});
         chk("mdu_wb_valid", {31'd0, mdu_wb_valid}, {31'd0, g.wbv});
         if (g.wbv) chk("mdu_wb_rd", {27'd0, mdu_wb_rd}, {27'd0, g.wbrd});
      end
   endtask

   task automatic adv();
      @(posedge clk);
      if (!rstn) launch_at = -1;
      else if (pend_launch) begin
         launch_at = cyc;
         m_rd      = pend_rd;
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      rstn = 1'b0;
      @(negedge clk);
      eval();
      chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
      chk("rst_wbrd", {27'd0, mdu_wb_rd}, 32'd0);
      adv();
      adv();
      rstn = 1'b1;

      // Forward priority and x0 suppression
      rs_EX = {5'd0, 5'd5}; rd_MEM = 5'd5; reg_write_MEM = 1'b1; rd_WB = 5'd5; reg_write_WB = 1'b1;
      eval(); chk("tp_mem", {30'd0, forward_sel[1:0]}, 32'd1); adv();
      reg_write_MEM = 1'b0;
      eval(); chk("tp_wb", {30'd0, forward_sel[1:0]}, 32'd2); adv();
      clear_inputs();
      rs_EX = {5'd0, 5'd3}; rd_MEM = 5'd0; reg_write_MEM = 1'b1;
      eval(); chk("tp_x0", {30'd0, forward_sel[3:2]}, 32'd0); adv();

      // Load-use: one-cycle stall, then bubble clears the load
      clear_inputs();
      mem_read_EX = 1'b1; reg_write_EX = 1'b1; rd_EX = 5'd7; rs_ID = {5'd7, 5'd3}; rs_used_ID = 2'b11;
      eval(); chk("tp_lu", {31'd0, stall_IF}, 32'd1); adv();
      mem_read_EX = 1'b0; reg_write_EX = 1'b0; rd_EX = 5'd0;
      eval(); chk("tp_lu_one", {31'd0, bubble_EX}, 32'd0); adv();
      mem_read_EX = 1'b1; reg_write_EX = 1'b1; rd_EX = 5'd7; rs_used_ID = 2'b01;
      eval(); chk("tp_lu_unused", {31'd0, stall_ID}, 32'd0); adv();

      // MDU launch rd=9, dependent reader in ID
      clear_inputs();
      is_mdu_EX = 1'b1; rd_EX = 5'd9; reg_write_EX = 1'b1;
      eval(); adv();
      clear_inputs();
      rs_ID = {5'd9, 5'd1}; rs_used_ID = 2'b11;
      for (int k = 1; k < LAT; k++) begin
         eval(); chk("tp_mdu_stall", {31'd0, stall_ID}, 32'd1); adv();
      end
      rs_EX = {5'd0, 5'd9};
      eval();
      chk("tp_wbv", {31'd0, mdu_wb_valid}, 32'd1);
      chk("tp_wbrd", {27'd0, mdu_wb_rd}, 32'd9);
      chk("tp_fwd_mdu", {30'd0, forward_sel[1:0]}, 32'd3);
      chk("tp_done_nostall", {31'd0, stall_IF}, 32'd0);
      adv();
      clear_inputs();
      eval(); chk("tp_idle", {31'd0, mdu_busy}, 32'd0); adv();

      // Second MDU waits in ID, then launches back-to-back in DONE
      is_mdu_EX = 1'b1; rd_EX = 5'd10;
      eval(); adv();
      clear_inputs();
      is_mdu_ID = 1'b1;
      for (int k = 1; k < LAT; k++) begin
         eval(); chk("tp_mdu2_stall", {31'd0, stall_IF}, 32'd1); adv();
      end
      is_mdu_ID = 1'b0; is_mdu_EX = 1'b1; rd_EX = 5'd11;
      eval(); chk("tp_b2b_rd", {27'd0, mdu_wb_rd}, 32'd10); adv();
      clear_inputs();
      eval(); chk("tp_b2b_busy", {31'd0, mdu_busy}, 32'd1); adv();
      for (int k = 2; k <= LAT + 1; k++) begin
         eval(); adv();
      end

      // Killed MDU op does not launch
      is_mdu_EX = 1'b1; kill_EX = 1'b1; rd_EX = 5'd12;
      eval(); adv();
      clear_inputs();
      eval(); chk("tp_kill", {31'd0, mdu_busy}, 32'd0); adv();

      // Reset mid-BUSY drops the pending op
      is_mdu_EX = 1'b1; rd_EX = 5'd13;
      eval(); adv();
      clear_inputs();
      eval(); adv();
      rstn = 1'b0;
      launch_at = -1;
      #1;
      chk("tp_rst_busy", {31'd0, mdu_busy}, 32'd0);
      eval(); adv();
      rstn = 1'b1;
      for (int k = 0; k < LAT + 2; k++) begin
         eval(); chk("tp_rst_nowb", {31'd0, mdu_wb_valid}, 32'd0); adv();
      end

      // Random traffic against the model
      for (int n = 0; n < 300; n++) begin
         rs_ID         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rs_EX         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rs_used_ID    = 2'($urandom_range(0, 3));
         rd_EX         = 5'($urandom_range(0, 7));
         rd_MEM        = 5'($urandom_range(0, 7));
         rd_WB         = 5'($urandom_range(0, 7));
         reg_write_EX  = 1'($urandom_range(0, 1));
         reg_write_MEM = 1'($urandom_range(0, 1));
         reg_write_WB  = 1'($urandom_range(0, 1));
         mem_read_EX   = ($urandom_range(0, 3) == 0);
         is_mdu_EX     = ($urandom_range(0, 4) == 0);
         is_mdu_ID     = ($urandom_range(0, 3) == 0);
         kill_EX       = ($urandom_range(0, 7) == 0);
         eval(); adv();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
